// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM encoding and helpers for the SPI NOR flash responder and its controller.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;

  localparam int unsigned PAGE_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRd,
    StWr,
    StStat,
    StId,
    StIgnore
  } flash_state_e;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    return {6'b000000, wel, wip};
  endfunction

endpackage

// File: rtl/spi_flash_responder_byte_if.sv
// SPI mode-0 byte interface: input synchronizers, edge detection, rx/tx shift registers.
module spi_flash_responder_byte_if (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spi_cs_n_i,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_data_i,
  output logic       cs_active_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       byte_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       tx_bit_o
);

  logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic       cs_prev_q, sck_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] tx_q;
  logic       cs_s, sck_s, mosi_s;
  logic       sck_rise, sck_fall;

  assign cs_s   = cs_sync_q[1];
  assign sck_s  = sck_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  // Gating with the previous cs_n lets a byte finishing in the cs_n-rise cycle still complete.
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
      sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
    end else if (cs_prev_q) begin
      bit_cnt_q <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= {rx_q[5:0], mosi_s};
    end
  end

  // A byte loaded on the 8th rising edge must survive the falling edge that follows it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q <= 8'h00;
    end else if (tx_load_i) begin
      tx_q <= tx_data_i;
    end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign cs_active_o  = ~cs_s;
  assign cs_fall_o    = ~cs_s & cs_prev_q;
  assign cs_rise_o    = cs_s & ~cs_prev_q;
  assign byte_valid_o = sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte_o    = {rx_q, mosi_s};
  assign tx_bit_o     = tx_q[7];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder: command FSM, status register, WIP timer and on-chip byte array.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4015,
  parameter int unsigned PROG_CYCLES = 64
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy
);

  localparam int unsigned TimerW = $clog2(PROG_CYCLES + 1);

  logic              cs_active, cs_fall, cs_rise, byte_valid, tx_bit;
  logic [7:0]        rx_byte;
  logic              tx_load;
  logic [7:0]        tx_data;

  flash_state_e      state_q, state_d;
  logic              wel_q, wel_d;
  logic              wip_q, wip_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [1:0]        addr_cnt_q, addr_cnt_d;
  logic              is_pp_q, is_pp_d;
  logic              pp_any_q, pp_any_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              prog_start;

  logic [7:0]        mem [0:2**ADDR_W-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr, addr_new;
  logic [7:0]        mem_wdata, mem_rdata;

  spi_flash_responder_byte_if u_byte_if (
    .clk_i        (sys_clk),
    .rst_ni       (sys_rst_n),
    .spi_cs_n_i   (spi_cs_n),
    .spi_sck_i    (spi_sck),
    .spi_mosi_i   (spi_mosi),
    .tx_load_i    (tx_load),
    .tx_data_i    (tx_data),
    .cs_active_o  (cs_active),
    .cs_fall_o    (cs_fall),
    .cs_rise_o    (cs_rise),
    .byte_valid_o (byte_valid),
    .rx_byte_o    (rx_byte),
    .tx_bit_o     (tx_bit)
  );

  // Upper address bits fall off the top of the shifter.
  assign addr_new = ADDR_W'({addr_sh_q, rx_byte});

  always_comb begin
    state_d    = state_q;
    wel_d      = wel_q;
    addr_d     = addr_q;
    addr_sh_d  = addr_sh_q;
    addr_cnt_d = addr_cnt_q;
    is_pp_d    = is_pp_q;
    pp_any_d   = pp_any_q;
    id_idx_d   = id_idx_q;
    tx_load    = 1'b0;
    tx_data    = 8'h00;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = rx_byte;
    mem_raddr  = addr_q;
    prog_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StCmd;
      end
      StCmd: begin
        if (byte_valid) begin
          state_d = StIgnore;
          if (!wip_q || (rx_byte == CMD_RDSR)) begin
            case (rx_byte)
              CMD_WREN: wel_d = 1'b1;
              CMD_WRDI: wel_d = 1'b0;
              CMD_RDSR: begin
                state_d = StStat;
                tx_load = 1'b1;
                tx_data = status_byte(wel_q, wip_q);
              end
              CMD_RDID: begin
                state_d  = StId;
                tx_load  = 1'b1;
                tx_data  = JEDEC_ID[23:16];
                id_idx_d = 2'd1;
              end
              CMD_READ: begin
                state_d    = StAddr;
                is_pp_d    = 1'b0;
                addr_cnt_d = 2'd0;
              end
              CMD_PP: begin
                if (wel_q) begin
                  state_d    = StAddr;
                  is_pp_d    = 1'b1;
                  addr_cnt_d = 2'd0;
                end
              end
              default: state_d = StIgnore;
            endcase
          end
        end
      end
      StAddr: begin
        if (byte_valid) begin
          addr_sh_d  = addr_new;
          addr_cnt_d = addr_cnt_q + 2'd1;
          if (addr_cnt_q == 2'd2) begin
            if (is_pp_q) begin
              state_d  = StWr;
              addr_d   = addr_new;
              pp_any_d = 1'b0;
            end else begin
              state_d   = StRd;
              mem_raddr = addr_new;
              tx_load   = 1'b1;
              tx_data   = mem_rdata;
              addr_d    = addr_new + ADDR_W'(1);
            end
          end
        end
      end
      StRd: begin
        if (byte_valid) begin
          tx_load = 1'b1;
          tx_data = mem_rdata;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      StWr: begin
        if (byte_valid) begin
          mem_we   = 1'b1;
          pp_any_d = 1'b1;
          // Column wraps inside the page; page bits stay put.
          addr_d   = {addr_q[ADDR_W-1:PAGE_BITS], addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
        end
      end
      StStat: begin
        if (byte_valid) begin
          tx_load = 1'b1;
          tx_data = status_byte(wel_q, wip_q);
        end
      end
      StId: begin
        if (byte_valid) begin
          tx_load = 1'b1;
          case (id_idx_q)
            2'd1:    tx_data = JEDEC_ID[15:8];
            2'd2:    tx_data = JEDEC_ID[7:0];
            default: tx_data = 8'h00;
          endcase
          if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    // Abort after the byte effects so a byte finishing on the cs_n edge still counts.
    if (cs_rise) begin
      if ((state_q == StWr) && pp_any_d) begin
        prog_start = 1'b1;
        wel_d      = 1'b0;
      end
      state_d = StIdle;
    end
  end

  always_comb begin
    wip_d   = wip_q;
    timer_d = timer_q;
    if (prog_start) begin
      wip_d   = 1'b1;
      timer_d = TimerW'(PROG_CYCLES);
    end else if (wip_q) begin
      timer_d = timer_q - TimerW'(1);
      if (timer_q == TimerW'(1)) wip_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      wel_q      <= 1'b0;
      wip_q      <= 1'b0;
      timer_q    <= '0;
      addr_q     <= '0;
      addr_sh_q  <= '0;
      addr_cnt_q <= 2'd0;
      is_pp_q    <= 1'b0;
      pp_any_q   <= 1'b0;
      id_idx_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      wel_q      <= wel_d;
      wip_q      <= wip_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      addr_sh_q  <= addr_sh_d;
      addr_cnt_q <= addr_cnt_d;
      is_pp_q    <= is_pp_d;
      pp_any_q   <= pp_any_d;
      id_idx_q   <= id_idx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign mem_rdata = mem[mem_raddr];

  assign spi_miso_oe = cs_active & ((state_q == StStat) || (state_q == StId) ||
                                    (state_q == StRd));
  assign spi_miso    = spi_miso_oe & tx_bit;
  assign busy        = wip_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder against a byte-array/status reference model.
module tb_spi_flash_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam logic [23:0] JEDEC  = 24'hEF4015;
  localparam int unsigned PROG   = 800;
  localparam int          HALF   = 100;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic spi_cs_n  = 1'b1;
  logic spi_sck   = 1'b0;
  logic spi_mosi  = 1'b0;
  logic spi_miso, spi_miso_oe, busy;

  always #10 sys_clk = ~sys_clk;

  spi_flash_responder #(
    .ADDR_W      (ADDR_W),
    .JEDEC_ID    (JEDEC),
    .PROG_CYCLES (PROG)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: array contents, which bytes are known, and the write-enable latch.
  logic [7:0] mem_m   [0:DEPTH-1];
  bit         valid_m [0:DEPTH-1];
  logic       wel_m = 1'b0;

  logic [7:0] txb [$];
  logic [7:0] rxb [$];
  logic [7:0] dat [$];
  logic       cmd_oe, dat_oe;

  int busy_cyc = 0;
  always @(negedge sys_clk) if (busy === 1'b1) busy_cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r,
                          output logic oe_any, output logic oe_all);
    r = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = d[i];
      #(HALF);
      r[i]   = spi_miso;
      oe_any = oe_any | spi_miso_oe;
      oe_all = oe_all & spi_miso_oe;
      spi_sck = 1'b1;
      #(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_txn(input int nrd);
    logic [7:0] r;
    logic a, b;
    rxb.delete();
    cmd_oe = 1'b0; dat_oe = 1'b1;
    spi_cs_n = 1'b0;
    #(HALF);
    foreach (txb[i]) begin
      spi_bits(txb[i], 8, r, a, b);
      cmd_oe = cmd_oe | a;
    end
    for (int k = 0; k < nrd; k++) begin
      spi_bits(8'h00, 8, r, a, b);
      rxb.push_back(r);
      dat_oe = dat_oe & b;
    end
    #(HALF);
    spi_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic do_cmd(input logic [7:0] op);
    txb = {op};
    run_txn(0);
  endtask

  task automatic do_wren();
    do_cmd(8'h06);
    wel_m = 1'b1;
  endtask

  task automatic do_wrdi();
    do_cmd(8'h04);
    wel_m = 1'b0;
  endtask

  task automatic do_rdsr(input string tag, input logic wip_exp);
    txb = {8'h05};
    run_txn(1);
    check_eq(tag, rxb[0], {6'b0, wel_m, wip_exp});
  endtask

  task automatic do_pp(input logic [23:0] a);
    int base, idx;
    txb = {8'h02, a[23:16], a[15:8], a[7:0]};
    foreach (dat[i]) txb.push_back(dat[i]);
    run_txn(0);
    if (wel_m && dat.size() > 0) begin
      base = int'(a) % DEPTH;
      foreach (dat[i]) begin
        idx = (base & 32'hF00) | ((base + i) & 32'hFF);
        mem_m[idx]   = dat[i];
        valid_m[idx] = 1'b1;
      end
      wel_m = 1'b0;
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int idx;
    txb = {8'h03, a[23:16], a[15:8], a[7:0]};
    run_txn(n);
    idx = int'(a) % DEPTH;
    for (int k = 0; k < n; k++) begin
      if (valid_m[idx]) check_eq($sformatf("rd_%03h", idx), rxb[k], mem_m[idx]);
      idx = (idx + 1) % DEPTH;
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 5000 && busy; c++) @(negedge sys_clk);
    #7;
    check_eq("busy_clear", busy, 1'b0);
  endtask

  initial begin
    #(1_500_000);
    $display("FAIL watchdog sim time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] id_v;
    logic [23:0] ra;
    logic [7:0]  r8, first8;
    logic        oa, ob;
    int          base_cyc, len;
    id_v = JEDEC;
    foreach (valid_m[i]) valid_m[i] = 1'b0;

    #7;
    #(HALF);
    check_eq("rst_miso", spi_miso, 1'b0);
    check_eq("rst_oe", spi_miso_oe, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    sys_rst_n = 1'b1;
    #(HALF);

    // Identification and oe window
    txb = {8'h9F};
    run_txn(4);
    check_eq("rdid_b0", rxb[0], id_v[23:16]);
    check_eq("rdid_b1", rxb[1], id_v[15:8]);
    check_eq("rdid_b2", rxb[2], id_v[7:0]);
    check_eq("rdid_pad", rxb[3], 8'h00);
    check_eq("rdid_cmd_oe", cmd_oe, 1'b0);
    check_eq("rdid_dat_oe", dat_oe, 1'b1);
    check_eq("oe_after_cs", spi_miso_oe, 1'b0);
    do_rdsr("rdsr_reset", 1'b0);

    // Seed known bytes and measure the program time
    do_wren();
    do_rdsr("rdsr_wel", 1'b0);
    dat.delete();
    for (int i = 0; i < 4; i++) dat.push_back(8'($urandom));
    base_cyc = busy_cyc;
    do_pp(24'h000010);
    wait_idle();
    check_eq("busy_len_seed", busy_cyc - base_cyc, PROG);
    do_rdsr("rdsr_after_pp", 1'b0);

    // PP without WREN must not write
    dat = {8'hAA};
    do_pp(24'h000010);
    check_eq("unprot_busy", busy, 1'b0);
    do_read(24'h000010, 4);
    do_rdsr("rdsr_prot", 1'b0);

    // Program, busy gating, polling
    do_wren();
    do_rdsr("rdsr_wel2", 1'b0);
    dat = {8'h11, 8'h22, 8'h33};
    base_cyc = busy_cyc;
    do_pp(24'h0000FE);
    check_eq("pp_busy", busy, 1'b1);
    txb = {8'h9F};
    run_txn(1);
    check_eq("gate_rdid_oe", cmd_oe | dat_oe, 1'b0);
    check_eq("gate_rdid_data", rxb[0], 8'h00);
    txb = {8'h06};
    run_txn(0);
    do_rdsr("rdsr_wip", 1'b1);
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits(8'h05, 8, r8, oa, ob);
    first8 = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      spi_bits(8'h00, 8, r8, oa, ob);
      if (k == 0) first8 = r8;
      if (r8 == 8'h00) break;
    end
    check_eq("poll_first", first8, 8'h01);
    check_eq("poll_done", r8, 8'h00);
    #(HALF);
    spi_cs_n = 1'b1;
    #(4 * HALF);
    wait_idle();
    check_eq("busy_len_pp", busy_cyc - base_cyc, PROG);
    do_rdsr("rdsr_post_poll", 1'b0);
    do_read(24'h0000FE, 2);
    do_read(24'h000000, 1);

    // Linear read wraps at the top of the array; upper address bits ignored
    do_wren();
    dat = {8'($urandom)};
    do_pp(24'h000FFF);
    wait_idle();
    ra = {8'($urandom), 4'h0, 12'hFFF};
    do_read(ra, 2);

    // Zero-byte PP keeps WEL, no programming
    do_wren();
    dat.delete();
    do_pp(24'h000100);
    check_eq("pp0_busy", busy, 1'b0);
    do_rdsr("rdsr_pp0", 1'b0);

    // PP aborted in the address phase leaves WEL set
    txb = {8'h02};
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits(8'h02, 8, r8, oa, ob);
    spi_bits(8'h00, 8, r8, oa, ob);
    spi_bits(8'h01, 4, r8, oa, ob);
    #(HALF);
    spi_cs_n = 1'b1;
    #(4 * HALF);
    check_eq("ppabort_busy", busy, 1'b0);
    do_rdsr("rdsr_ppabort", 1'b0);
    do_wrdi();
    do_rdsr("rdsr_wrdi", 1'b0);

    // Randomized programs and read-back
    for (int it = 0; it < 5; it++) begin
      if ($urandom_range(3, 0) != 0) do_wren();
      ra  = 24'($urandom);
      len = int'($urandom_range(6, 1));
      dat.delete();
      for (int i = 0; i < len; i++) dat.push_back(8'($urandom));
      do_pp(ra);
      wait_idle();
      do_rdsr($sformatf("rdsr_rand%0d", it), 1'b0);
      do_read(ra, len);
    end

    // READ aborted mid-address, then a clean RDID
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits(8'h03, 8, r8, oa, ob);
    spi_bits(8'h00, 8, r8, oa, ob);
    spi_bits(8'hF0, 4, r8, oa, ob);
    #(HALF);
    spi_cs_n = 1'b1;
    #(4 * HALF);
    txb = {8'h9F};
    run_txn(3);
    check_eq("abort_rdid_b0", rxb[0], id_v[23:16]);
    check_eq("abort_rdid_b1", rxb[1], id_v[15:8]);
    check_eq("abort_rdid_b2", rxb[2], id_v[7:0]);

    // Reset in the middle of a read
    do_wren();
    spi_cs_n = 1'b0;
    #(HALF);
    spi_bits(8'h03, 8, r8, oa, ob);
    spi_bits(8'h00, 8, r8, oa, ob);
    spi_bits(8'h00, 8, r8, oa, ob);
    spi_bits(8'hFE, 8, r8, oa, ob);
    spi_bits(8'h00, 4, r8, oa, ob);
    check_eq("midrd_oe", spi_miso_oe, 1'b1);
    sys_rst_n = 1'b0;
    #2;
    check_eq("midrd_rst_miso", spi_miso, 1'b0);
    check_eq("midrd_rst_oe", spi_miso_oe, 1'b0);
    check_eq("midrd_rst_busy", busy, 1'b0);
    spi_cs_n = 1'b1;
    #98;
    sys_rst_n = 1'b1;
    #(HALF);
    wel_m = 1'b0;
    do_rdsr("rdsr_after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
